// File: rtl/picorv32_mem_responder_if.sv
// -----------------------------------------------------------------------------
// picorv32_mem_responder_if
//   PicoRV32 native memory bus bundle.
//
//   Signals
//     mem_valid  core request
//     mem_instr  request is an instruction fetch
//     mem_addr   byte address [31:0]
//     mem_wdata  write data [31:0]
//     mem_wstrb  byte write strobes [3:0], 0 means read
//     mem_ready  transfer complete, single-cycle pulse
//     mem_rdata  read data [31:0], valid only while mem_ready=1
//
//   Modports
//     master  the core side (drives the request)
//     slave   the memory side (drives ready/rdata)
// -----------------------------------------------------------------------------
interface picorv32_mem_responder_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/picorv32_mem_responder.sv
// -----------------------------------------------------------------------------
// picorv32_mem_responder
//   Small word-addressed memory answering PicoRV32 native bus requests with a
//   configurable number of stall cycles (driven by stall_req).
//
//   Parameters
//     DEPTH     number of 32-bit words (power of two, 2..64)
//     MAX_WAIT  maximum stall cycles per transfer (0..15)
//
//   Ports
//     clk           sole clock, rising edge
//     resetn        asynchronous active-low reset; also clears the store
//     bus           picorv32_mem_responder_if.slave (request in, ready/rdata out)
//     stall_req     stretch the current transfer while in WAIT
//     protocol_err  sticky flag: request changed or dropped while in WAIT
//
//   Build option
//     PICORV32_MEM_PROTOCOL_CHECK_EN  when defined, builds the request-stability
//     checker behind protocol_err; otherwise protocol_err is tied to 0.
//
//   Transfer timing: request seen in IDLE -> WAIT (0..MAX_WAIT extra cycles)
//   -> RESP (mem_ready=1 for one cycle) -> IDLE.
// -----------------------------------------------------------------------------
module picorv32_mem_responder #(
    parameter int DEPTH    = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic                           clk,
    input  logic                           resetn,
    picorv32_mem_responder_if.slave        bus,
    input  logic                           stall_req,
    output logic                           protocol_err
);

    localparam int          AW     = $clog2(DEPTH);
    localparam logic [3:0]  MAX_W  = 4'(MAX_WAIT);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    state;
    logic [3:0]    wait_cnt;

    // Captured request
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic          instr_q;

    logic [31:0]   store [DEPTH];

    logic [AW-1:0] idx_q;
    logic          stay_wait;
    logic          go_resp;

    // Higher address bits alias onto the same words; byte offset is ignored.
    assign idx_q     = addr_q[AW+1:2];
    assign stay_wait = stall_req && (wait_cnt < MAX_W);
    assign go_resp   = (state == WAIT) && !stay_wait;

    // ------------------------------------------------------------------
    // Control FSM and response registers
    // ------------------------------------------------------------------
    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            instr_q       <= 1'b0;
            bus.mem_ready <= 1'b0;
            bus.mem_rdata <= '0;
        end else begin
            // Response outputs are single-cycle; they default back to 0.
            bus.mem_ready <= 1'b0;
            bus.mem_rdata <= '0;
            case (state)
                IDLE: begin
                    if (bus.mem_valid) begin
                        addr_q   <= bus.mem_addr;
                        wdata_q  <= bus.mem_wdata;
                        wstrb_q  <= bus.mem_wstrb;
                        instr_q  <= bus.mem_instr;
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (stay_wait) begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end else begin
                        state         <= RESP;
                        bus.mem_ready <= 1'b1;
                        // Writes answer with 0; the store write lands on this
                        // same edge so a read here always sees the old word.
                        bus.mem_rdata <= (wstrb_q == 4'b0000) ? store[idx_q] : '0;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Store: byte-masked write on the WAIT->RESP edge
    // ------------------------------------------------------------------
    // NOTE: the store is reset on purpose (contents must read as zero after
    // reset), so it is built from flops rather than a RAM macro.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                store[i] <= '0;
            end
        end else if (go_resp && (wstrb_q != 4'b0000)) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) begin
                    store[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional request-stability checker
    // ------------------------------------------------------------------
`ifdef PICORV32_MEM_PROTOCOL_CHECK_EN
    logic req_changed;

    // NOTE: every combinational output gets a default first so no latch is
    // inferred on any path.
    always_comb begin
        req_changed = 1'b0;
        if (state == WAIT) begin
            req_changed = !bus.mem_valid
                       || (bus.mem_addr  != addr_q)
                       || (bus.mem_wdata != wdata_q)
                       || (bus.mem_wstrb != wstrb_q)
                       || (bus.mem_instr != instr_q);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            protocol_err <= 1'b0;
        end else if (req_changed) begin
            protocol_err <= 1'b1;
        end
    end
`else
    assign protocol_err = 1'b0;

    // Captured bits that only the checker would read; mem_instr never affects
    // data behaviour.
    logic unused_capture;
    assign unused_capture = ^{addr_q[31:AW+2], addr_q[1:0], instr_q};
`endif

endmodule

// File: doc/picorv32_mem_responder.md
PICORV32_MEM_RESPONDER -- requirements
Module: picorv32_mem_responder

Interface
REQ-001 Parameter DEPTH, default 16, number of 32-bit words in the internal store (power of two, 2..64).
REQ-002 Parameter MAX_WAIT, default 4, maximum number of stall cycles inserted per transfer (0..15).
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 mem_valid  input  1  core request.
REQ-006 mem_instr  input  1  request is an instruction fetch.
REQ-007 mem_addr  input  32  byte address.
REQ-008 mem_wdata  input  32  write data.
REQ-009 mem_wstrb  input  4  byte write strobes; 0 means read.
REQ-010 stall_req  input  1  free stall request (formal-driven or bench-driven).
REQ-011 mem_ready  output  1  transfer complete, single-cycle pulse.
REQ-012 mem_rdata  output  32  read data, valid only while mem_ready=1.
REQ-013 protocol_err  output  1  sticky request-protocol violation flag.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT, RESP.
REQ-015 In IDLE with mem_valid=1 the block SHALL capture mem_addr, mem_wdata, mem_wstrb and mem_instr, clear wait_cnt, and enter WAIT.
REQ-016 In WAIT, if stall_req=1 and wait_cnt<MAX_WAIT, the block SHALL stay in WAIT and increment wait_cnt; otherwise it SHALL enter RESP.
REQ-017 In RESP, mem_ready SHALL be 1 for exactly one cycle; the next state SHALL be IDLE.
REQ-018 Latency from the first IDLE cycle with mem_valid=1 to mem_ready SHALL be 2 cycles minimum and 2+MAX_WAIT cycles maximum.
REQ-019 Word index SHALL be captured addr[log2(DEPTH)+1:2]; higher address bits SHALL be ignored (aliasing); addr[1:0] SHALL be ignored.
REQ-020 Read (captured wstrb=0): mem_rdata SHALL equal the store word at the index during RESP.
REQ-021 Write: on the WAIT->RESP edge, each byte i with wstrb[i]=1 SHALL be written from wdata[8i+7:8i]; other bytes SHALL be unchanged; mem_rdata SHALL be 0 during RESP.
REQ-022 mem_rdata SHALL be 0 whenever mem_ready=0.
REQ-023 mem_valid=1 in the cycle immediately after RESP SHALL be treated as a new request from IDLE (back-to-back supported, no bubble beyond IDLE).
REQ-024 stall_req SHALL be ignored outside WAIT.
REQ-025 mem_instr SHALL not affect data behaviour; fetches and loads SHALL read the same store.

Reset
REQ-026 resetn=0 SHALL asynchronously force state IDLE, wait_cnt 0, mem_ready 0, mem_rdata 0, protocol_err 0, and all captured request registers 0.
REQ-027 Store contents SHALL be cleared to zero while resetn=0.
REQ-028 Reset asserted during WAIT or RESP SHALL abort the transfer with no store write; after deassertion the first mem_valid SHALL start a fresh transfer.

Configuration
REQ-029 With macro PICORV32_MEM_PROTOCOL_CHECK_EN defined, protocol_err SHALL set (and stay set until reset) when, in WAIT, mem_valid=0 or mem_addr, mem_wdata, mem_wstrb or mem_instr differ from the captured values.
REQ-030 Without PICORV32_MEM_PROTOCOL_CHECK_EN, protocol_err SHALL be constant 0 and no comparison logic SHALL be built; all other behaviour SHALL be identical.

Verification
REQ-031 After reset, read addr 0x0000_0008, stall_req=0 -> mem_ready at cycle 2, mem_rdata=0x0000_0000.
REQ-032 Write addr 0x0000_0004 wdata 0xA1B2C3D4 wstrb 0b0101, then read 0x0000_0004 -> mem_rdata=0x00B200D4.
REQ-033 DEPTH=16, write 0x11223344 to 0x0000_0040, read 0x0000_0000 -> mem_rdata=0x11223344 (aliasing).
REQ-034 MAX_WAIT=4, stall_req held 1 -> mem_ready at exactly cycle 6, one-cycle pulse.
REQ-035 Macro defined, mem_addr changed 0x10->0x14 mid-WAIT -> protocol_err=1 and remains 1 after mem_ready; macro undefined, same stimulus -> protocol_err=0.
REQ-036 Write wstrb 0xF to addr 0x0 with resetn pulsed low in WAIT -> mem_ready never asserts for that transfer, subsequent read of 0x0 returns 0x00000000.
